// File: rtl/tqvp_irq_arbiter_pkg.sv
// Shared constants for the TinyQV interrupt arbiter peripheral: register map
// and CLAIM word layout.
package tqvp_irq_arbiter_pkg;

    localparam logic [5:0] ADDR_PENDING  = 6'h00;
    localparam logic [5:0] ADDR_ENABLE   = 6'h04;
    localparam logic [5:0] ADDR_EDGE_CFG = 6'h08;
    localparam logic [5:0] ADDR_SWTRIG   = 6'h0C;
    localparam logic [5:0] ADDR_CLAIM    = 6'h10;
    localparam logic [5:0] ADDR_COMPLETE = 6'h14;
    localparam logic [5:0] ADDR_STATUS   = 6'h18;

    localparam int unsigned NUM_SRC_MAX     = 7;
    localparam int unsigned CLAIM_VALID_BIT = 31;

endpackage

// File: rtl/tqvp_rr_pick.sv
// Combinational round-robin picker: first request at index >= ptr, wrapping to
// the lowest request when nothing sits at or above the pointer.
module tqvp_rr_pick #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [2:0]         ptr,
    output logic [2:0]         grant,
    output logic               valid
);

    logic       hi_found;
    logic [2:0] hi_grant;
    logic [2:0] lo_grant;

    // Descending scan so the last hit kept is the lowest index in each range.
    always_comb begin
        hi_found = 1'b0;
        hi_grant = 3'd0;
        lo_grant = 3'd0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_grant = 3'(i);
                if (i >= int'(ptr)) begin
                    hi_grant = 3'(i);
                    hi_found = 1'b1;
                end
            end
        end
        valid = |req;
        grant = hi_found ? hi_grant : lo_grant;
    end

endmodule

// File: rtl/tqvp_irq_arbiter.sv
// TinyQV peripheral sharing user_interrupt among NUM_SRC external sources with
// per-source enable/edge config, round-robin arbitration and claim/complete.
module tqvp_irq_arbiter
    import tqvp_irq_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] prev_in_q;
    logic               in_service_q, in_service_d;
    logic [2:0]         claimed_id_q, claimed_id_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [31:0]        data_out_q, data_out_d;
    logic               data_ready_q;
    logic               rd_busy_q, rd_busy_d;
    logic               irq_q, irq_d;

    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] candidates;
    logic [NUM_SRC-1:0] set_mask, clr_mask;
    logic [2:0]         grant;
    logic               grant_valid;
    logic               wr, rd, rd_capture, claim_ok, claim;
    logic [31:0]        rdata;
    logic [7:0]         pend8;
    logic               unused;

    assign unused = ^{data_in[31:NUM_SRC], ui_in[7:NUM_SRC]};

    assign src        = ui_in[NUM_SRC-1:0];
    assign candidates = pending_q & enable_q;
    assign wr         = (data_write_n != 2'b11);
    assign rd         = (data_read_n != 2'b11);
    assign rd_capture = rd && !rd_busy_q;
    assign claim_ok   = grant_valid && !in_service_q;
    assign claim      = rd_capture && (address == ADDR_CLAIM) && claim_ok;

    tqvp_rr_pick #(
        .NUM_SRC(NUM_SRC)
    ) u_pick (
        .req   (candidates),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        rdata = 32'h0;
        case (address)
            ADDR_PENDING:  rdata = 32'(pending_q);
            ADDR_ENABLE:   rdata = 32'(enable_q);
            ADDR_EDGE_CFG: rdata = 32'(edge_q);
            ADDR_CLAIM: begin
                if (claim_ok) begin
                    rdata[CLAIM_VALID_BIT] = 1'b1;
                    rdata[2:0]             = grant;
                end
            end
            ADDR_STATUS:   rdata = {24'h0, in_service_q, 4'h0, claimed_id_q};
            default:       rdata = 32'h0;
        endcase
    end

    always_comb begin
        set_mask = (edge_q & src & ~prev_in_q) | (~edge_q & src);
        if (wr && address == ADDR_SWTRIG) begin
            set_mask = set_mask | data_in[NUM_SRC-1:0];
        end
        clr_mask = '0;
        if (wr && address == ADDR_PENDING) begin
            clr_mask = data_in[NUM_SRC-1:0];
        end
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (claim && grant == 3'(i)) begin
                clr_mask[i] = 1'b1;
            end
        end
        // Set wins over a simultaneous clear.
        pending_d = (pending_q & ~clr_mask) | set_mask;

        enable_d = (wr && address == ADDR_ENABLE) ? data_in[NUM_SRC-1:0] : enable_q;
        edge_d   = (wr && address == ADDR_EDGE_CFG) ? data_in[NUM_SRC-1:0] : edge_q;

        in_service_d = in_service_q;
        claimed_id_d = claimed_id_q;
        rr_ptr_d     = rr_ptr_q;
        if (claim) begin
            in_service_d = 1'b1;
            claimed_id_d = grant;
            rr_ptr_d     = (grant == 3'(NUM_SRC - 1)) ? 3'd0 : grant + 3'd1;
        end else if (wr && address == ADDR_COMPLETE) begin
            in_service_d = 1'b0;
        end

        data_out_d = rd_capture ? rdata : data_out_q;
        rd_busy_d  = rd_capture ? 1'b1 : (rd ? rd_busy_q : 1'b0);
        irq_d      = !in_service_d && |(pending_d & enable_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            enable_q     <= '0;
            edge_q       <= '0;
            prev_in_q    <= '1;
            in_service_q <= 1'b0;
            claimed_id_q <= 3'd0;
            rr_ptr_q     <= 3'd0;
            data_out_q   <= 32'h0;
            data_ready_q <= 1'b0;
            rd_busy_q    <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            edge_q       <= edge_d;
            prev_in_q    <= src;
            in_service_q <= in_service_d;
            claimed_id_q <= claimed_id_d;
            rr_ptr_q     <= rr_ptr_d;
            data_out_q   <= data_out_d;
            data_ready_q <= rd_capture;
            rd_busy_q    <= rd_busy_d;
            irq_q        <= irq_d;
        end
    end

    assign pend8          = 8'(pending_q);
    assign uo_out         = {in_service_q, claimed_id_q, pend8[3:0]};
    assign data_out       = data_out_q;
    assign data_ready     = data_ready_q;
    assign user_interrupt = irq_q;

endmodule
